// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch sequencer and its return-address stack.
// Optional macro FETCH_SEQ_RAS_CHECK_EN adds the ERR state to state_e.
package fetch_pkg;

    localparam int PC_W_DEF      = 16;
    localparam int ROM_AW_DEF    = 10;
    localparam int RAS_DEPTH_DEF = 8;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
`ifdef FETCH_SEQ_RAS_CHECK_EN
        ,
        ERR  = 2'd3
`endif
    } state_e;

    typedef enum logic [2:0] {
        SEL_HOLD = 3'd0,
        SEL_RET  = 3'd1,
        SEL_CALL = 3'd2,
        SEL_BR   = 3'd3,
        SEL_SEQ  = 3'd4
    } sel_e;

    // Width of an occupancy counter able to hold 0..n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/fetch_ras.sv
// Circular return-address stack: push/pop of ROM addresses, with top, depth, full, empty.
// Ports: clk, rst_s, push_i, pop_i, data_i in; top_o, depth_o, full_o, empty_o out.
module fetch_ras
    import fetch_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH_DEF,
    parameter int AW    = ROM_AW_DEF
) (
    input  logic                     clk,
    input  logic                     rst_s,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [AW-1:0]            data_i,
    output logic [AW-1:0]            top_o,
    output logic [cnt_w(DEPTH)-1:0]  depth_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [AW-1:0] mem_q [DEPTH];
    logic [PW-1:0] sp_q, sp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_en;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign depth_o = cnt_q;
    // sp_q is the next write slot; the newest entry sits just below it.
    assign top_o   = empty_o ? '0 : mem_q[sp_q - 1'b1];

    always_comb begin
        sp_d  = sp_q;
        cnt_d = cnt_q;
        wr_en = 1'b0;
        if (push_i && !pop_i) begin
            // When full the write lands on the oldest slot and depth saturates.
            wr_en = 1'b1;
            sp_d  = sp_q + 1'b1;
            if (!full_o) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (pop_i && !push_i && !empty_o) begin
            sp_d  = sp_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_s) begin
            sp_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
            if (wr_en) begin
                mem_q[sp_q] <= data_i;
            end
        end
    end

endmodule

// File: rtl/fetch_seq.sv
// Fetch sequencer: owns the PC and picks the next ROM address by priority
// hold > ret > call > br_taken > sequential, with a hardware return-address stack.
// Ports: clk, rst_s, hold, br_taken, br_target, call, call_target, ret in;
//        rom_addr (comb), pc, fetch_valid, ras_depth, ras_err (registered) out.
// Macro FETCH_SEQ_RAS_CHECK_EN: stack over/underflow raises sticky ras_err and parks in ERR.
module fetch_seq
    import fetch_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int ROM_AW    = ROM_AW_DEF,
    parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst_s,
    input  logic                         hold,
    input  logic                         br_taken,
    input  logic [PC_W-1:0]              br_target,
    input  logic                         call,
    input  logic [PC_W-1:0]              call_target,
    input  logic                         ret,
    output logic [ROM_AW-1:0]            rom_addr,
    output logic [PC_W-1:0]              pc,
    output logic                         fetch_valid,
    output logic [cnt_w(RAS_DEPTH)-1:0]  ras_depth
`ifdef FETCH_SEQ_RAS_CHECK_EN
    ,
    output logic                         ras_err
`endif
);

`ifdef FETCH_SEQ_RAS_CHECK_EN
    localparam bit RAS_CHK = 1'b1;
`else
    localparam bit RAS_CHK = 1'b0;
`endif

    state_e              state_q, state_d;
    sel_e                sel;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic                fv_q, fv_d;
    logic [ROM_AW-1:0]   addr, pc_lo, pc_inc, ras_top;
    logic                ras_push, ras_pop, ras_full, ras_empty;
    logic                live, fault, upd;

    assign pc_lo  = pc_q[ROM_AW-1:0];
    assign pc_inc = pc_lo + 1'b1;
    assign live   = (state_q == RUN) || (state_q == HOLD);

    // Fixed-priority request decode.
    always_comb begin
        sel = SEL_SEQ;
        priority case (1'b1)
            hold:     sel = SEL_HOLD;
            ret:      sel = SEL_RET;
            call:     sel = SEL_CALL;
            br_taken: sel = SEL_BR;
            default:  sel = SEL_SEQ;
        endcase
    end

    // Only meaningful with checking enabled; otherwise the stack wraps/zeroes.
    assign fault = RAS_CHK && live &&
                   (((sel == SEL_RET) && ras_empty) ||
                    ((sel == SEL_CALL) && ras_full));

    // State register.
    always_ff @(posedge clk) begin
        if (rst_s) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN, HOLD: begin
                if (sel == SEL_HOLD) begin
                    state_d = HOLD;
`ifdef FETCH_SEQ_RAS_CHECK_EN
                end else if (fault) begin
                    state_d = ERR;
`endif
                end else begin
                    state_d = RUN;
                end
            end
`ifdef FETCH_SEQ_RAS_CHECK_EN
            ERR: state_d = ERR;
`endif
            default: state_d = BOOT;
        endcase
    end

    // Output / datapath control.
    always_comb begin
        addr     = '0;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        upd      = 1'b0;
        fv_d     = fv_q;
        unique case (state_q)
            BOOT: begin
                fv_d = 1'b0;
                upd  = 1'b1;
            end
            RUN, HOLD: begin
                if (fault) begin
                    addr = pc_lo;
                    fv_d = 1'b0;
                end else begin
                    unique case (sel)
                        SEL_HOLD: addr = pc_lo;
                        SEL_RET: begin
                            addr    = ras_top;
                            ras_pop = 1'b1;
                            upd     = 1'b1;
                            fv_d    = 1'b0;
                        end
                        SEL_CALL: begin
                            addr     = call_target[ROM_AW-1:0];
                            ras_push = 1'b1;
                            upd      = 1'b1;
                            fv_d     = 1'b0;
                        end
                        SEL_BR: begin
                            addr = br_target[ROM_AW-1:0];
                            upd  = 1'b1;
                            fv_d = 1'b0;
                        end
                        default: begin
                            addr = pc_inc;
                            upd  = 1'b1;
                            fv_d = 1'b1;
                        end
                    endcase
                end
            end
            default: begin
                addr = pc_lo;
                fv_d = 1'b0;
            end
        endcase
        if (rst_s) begin
            addr = '0;
        end
    end

    assign pc_d = upd ? PC_W'(addr) : pc_q;

    always_ff @(posedge clk) begin
        if (rst_s) begin
            pc_q <= '0;
            fv_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            fv_q <= fv_d;
        end
    end

`ifdef FETCH_SEQ_RAS_CHECK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst_s) begin
            err_q <= 1'b0;
        end else if (fault) begin
            err_q <= 1'b1;
        end
    end

    assign ras_err = err_q;
`endif

    fetch_ras #(
        .DEPTH (RAS_DEPTH),
        .AW    (ROM_AW)
    ) u_ras (
        .clk     (clk),
        .rst_s   (rst_s),
        .push_i  (ras_push),
        .pop_i   (ras_pop),
        .data_i  (pc_inc),
        .top_o   (ras_top),
        .depth_o (ras_depth),
        .full_o  (ras_full),
        .empty_o (ras_empty)
    );

    assign rom_addr    = addr;
    assign pc          = pc_q;
    assign fetch_valid = fv_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Self-checking bench for fetch_seq: queue-based reference model compared every
// cycle, plus directed vectors with literal expectations.
module tb_fetch_seq;

    localparam int PC_W      = 16;
    localparam int ROM_AW    = 10;
    localparam int RAS_DEPTH = 8;
    localparam int AMASK     = (1 << ROM_AW) - 1;

    logic              clk = 1'b0;
    logic              rst_s = 1'b1;
    logic              hold = 1'b0;
    logic              br_taken = 1'b0;
    logic [PC_W-1:0]   br_target = '0;
    logic              call = 1'b0;
    logic [PC_W-1:0]   call_target = '0;
    logic              ret = 1'b0;
    logic [ROM_AW-1:0] rom_addr;
    logic [PC_W-1:0]   pc;
    logic              fetch_valid;
    logic [3:0]        ras_depth;
`ifdef FETCH_SEQ_RAS_CHECK_EN
    logic              ras_err;
`endif

    fetch_seq #(
        .PC_W      (PC_W),
        .ROM_AW    (ROM_AW),
        .RAS_DEPTH (RAS_DEPTH)
    ) dut (
        .clk         (clk),
        .rst_s       (rst_s),
        .hold        (hold),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .call        (call),
        .call_target (call_target),
        .ret         (ret),
        .rom_addr    (rom_addr),
        .pc          (pc),
        .fetch_valid (fetch_valid),
        .ras_depth   (ras_depth)
`ifdef FETCH_SEQ_RAS_CHECK_EN
        ,
        .ras_err     (ras_err)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: program counter, bubble flag, and the stack as a queue
    // whose back is the most recent return address.
    bit m_boot = 1'b1;
    int m_pc   = 0;
    bit m_fv   = 1'b0;
    int m_stk[$];

    function automatic int exp_addr();
        if (rst_s) return 0;
        if (m_boot) return 0;
        if (hold) return m_pc;
        if (ret) return (m_stk.size() > 0) ? m_stk[$] : 0;
        if (call) return int'(call_target) & AMASK;
        if (br_taken) return int'(br_target) & AMASK;
        return (m_pc + 1) & AMASK;
    endfunction

    int m_a;
    bit m_redir;

    always @(posedge clk) begin
        m_a     = exp_addr();
        m_redir = ret || call || br_taken;
        if (rst_s) begin
            m_boot = 1'b1;
            m_pc   = 0;
            m_fv   = 1'b0;
            m_stk.delete();
        end else if (m_boot) begin
            m_boot = 1'b0;
            m_pc   = 0;
            m_fv   = 1'b0;
        end else if (!hold) begin
            if (ret) begin
                if (m_stk.size() > 0) void'(m_stk.pop_back());
            end else if (call) begin
                m_stk.push_back((m_pc + 1) & AMASK);
                if (m_stk.size() > RAS_DEPTH) void'(m_stk.pop_front());
            end
            m_pc = m_a;
            m_fv = !m_redir;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("rom_addr", 32'(rom_addr), 32'(exp_addr()));
            chk("pc", 32'(pc), 32'(m_pc));
            chk("fetch_valid", 32'(fetch_valid), 32'(m_fv));
            chk("ras_depth", 32'(ras_depth), 32'(m_stk.size()));
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic go_to(input int target);
        br_taken  = 1'b1;
        br_target = PC_W'(target);
        step();
        br_taken  = 1'b0;
    endtask

    task automatic run_to(input int target);
        int g;
        g = 0;
        while (m_pc != target && g < 2000) begin
            step();
            g++;
        end
        if (m_pc != target) chk("run_to_timeout", 32'(m_pc), 32'(target));
    endtask

    int exp_pc[5] = '{0, 0, 1, 2, 3};
    int exp_fv[5] = '{0, 0, 1, 1, 1};

    initial begin
        @(posedge clk);
        #1 chk_en = 1'b1;
        @(posedge clk);
        #2 rst_s = 1'b0;

        // Reset release and free run.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("boot_pc", 32'(pc), 32'(exp_pc[i]));
            chk("boot_fv", 32'(fetch_valid), 32'(exp_fv[i]));
            step();
        end

        // Taken branch and one bubble.
        run_to(5);
        br_taken  = 1'b1;
        br_target = 16'h0123;
        @(negedge clk);
        chk("br_rom", 32'(rom_addr), 32'h123);
        step();
        br_taken = 1'b0;
        @(negedge clk);
        chk("br_pc", 32'(pc), 32'h123);
        chk("br_bubble", 32'(fetch_valid), 32'h0);
        step();
        @(negedge clk);
        chk("br_next_pc", 32'(pc), 32'h124);
        chk("br_next_fv", 32'(fetch_valid), 32'h1);

        // Upper target bits discarded.
        br_taken  = 1'b1;
        br_target = 16'hF456;
        @(negedge clk);
        chk("br_trunc_rom", 32'(rom_addr), 32'h056);
        step();
        br_taken = 1'b0;
        @(negedge clk);
        chk("br_trunc_pc", 32'(pc), 32'h056);

        // Call then return.
        go_to(16'h10);
        call        = 1'b1;
        call_target = 16'h0200;
        @(negedge clk);
        chk("call_rom", 32'(rom_addr), 32'h200);
        step();
        call = 1'b0;
        @(negedge clk);
        chk("call_pc", 32'(pc), 32'h200);
        chk("call_depth", 32'(ras_depth), 32'd1);
        run_to(16'h203);
        ret = 1'b1;
        @(negedge clk);
        chk("ret_rom", 32'(rom_addr), 32'h011);
        step();
        ret = 1'b0;
        @(negedge clk);
        chk("ret_pc", 32'(pc), 32'h011);
        chk("ret_depth", 32'(ras_depth), 32'd0);

        // Hold dominates branch and call.
        go_to(6);
        step();
        hold        = 1'b1;
        br_taken    = 1'b1;
        br_target   = 16'h00AA;
        call        = 1'b1;
        call_target = 16'h0300;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_pc", 32'(pc), 32'd7);
            chk("hold_rom", 32'(rom_addr), 32'd7);
            chk("hold_depth", 32'(ras_depth), 32'd0);
            chk("hold_fv", 32'(fetch_valid), 32'd1);
            step();
        end
        hold = 1'b0;
        call = 1'b0;
        @(negedge clk);
        chk("unhold_rom", 32'(rom_addr), 32'h0AA);
        step();
        br_taken = 1'b0;
        @(negedge clk);
        chk("unhold_pc", 32'(pc), 32'h0AA);

        // ret beats call and branch; call beats branch.
        call        = 1'b1;
        call_target = 16'h0050;
        step();
        ret         = 1'b1;
        call_target = 16'h0300;
        br_taken    = 1'b1;
        br_target   = 16'h0111;
        @(negedge clk);
        chk("ret_wins_rom", 32'(rom_addr), 32'h0AB);
        step();
        ret = 1'b0;
        call_target = 16'h0060;
        br_target   = 16'h0222;
        step();
        call     = 1'b0;
        br_taken = 1'b0;
        @(negedge clk);
        chk("call_wins_pc", 32'(pc), 32'h060);
        chk("call_wins_depth", 32'(ras_depth), 32'd1);
        ret = 1'b1;
        step();
        ret = 1'b0;
        @(negedge clk);
        chk("ret2_pc", 32'(pc), 32'h0AC);

        // Sequential wrap at top of ROM space.
        go_to(16'h3FE);
        step();
        @(negedge clk);
        chk("wrap_rom", 32'(rom_addr), 32'h0);
        step();
        @(negedge clk);
        chk("wrap_pc", 32'(pc), 32'h0);

        // Nine nested calls overflow an eight-entry stack.
        call = 1'b1;
        for (int k = 0; k < 9; k++) begin
            call_target = PC_W'(16'h100 + 16'h10 * k);
            step();
        end
        call = 1'b0;
        @(negedge clk);
        chk("ovf_depth", 32'(ras_depth), 32'd8);
        chk("ovf_pc", 32'(pc), 32'h180);
        ret = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            @(negedge clk);
            chk("ovf_ret_pc", 32'(pc), 32'(16'h171 - 16'h10 * k));
        end
        chk("ovf_empty", 32'(ras_depth), 32'd0);
        step();
        ret = 1'b0;
        @(negedge clk);
        chk("underflow_pc", 32'(pc), 32'h0);
        chk("underflow_depth", 32'(ras_depth), 32'd0);

        // Reset during HOLD.
        call        = 1'b1;
        call_target = 16'h0090;
        step();
        call = 1'b0;
        hold = 1'b1;
        step(2);
        rst_s = 1'b1;
        @(negedge clk);
        chk("rst_rom", 32'(rom_addr), 32'h0);
        step();
        @(negedge clk);
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_depth", 32'(ras_depth), 32'd0);
        chk("rst_fv", 32'(fetch_valid), 32'd0);
        rst_s = 1'b0;
        hold  = 1'b0;
        step(4);
        @(negedge clk);
        chk("rerun_pc", 32'(pc), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
        $fatal(1);
    end

endmodule

// File: doc/fetch_seq.md
# fetch_seq

Fetch sequencer that owns the program counter and decides, every cycle, which address is fetched from instruction ROM. It arbitrates among the decoder's hold, the ALU's taken-branch, and call/return requests, in fixed priority. Return addresses are kept in an internal hardware return-address stack, so a return needs no RAM read. Sits between decoder/ALU and the instruction ROM, and replaces the old ad-hoc PC update path.

## Interface
- PC_W, 16, width of architectural PC
- ROM_AW, 10, instruction ROM address width (ROM_AW <= PC_W)
- RAS_DEPTH, 8, return-address stack entries (power of two, >= 2)

- clk  in  1  single clock, all state on rising edge
- rst_s  in  1  synchronous, active-high reset
- hold  in  1  decoder stall: freeze PC and stack
- br_taken  in  1  ALU: branch taken this cycle
- br_target  in  PC_W  ALU branch target
- call  in  1  decoder: call instruction in execute
- call_target  in  PC_W  call destination
- ret  in  1  decoder: return instruction in execute
- rom_addr  out  ROM_AW  combinational next fetch address to ROM
- pc  out  PC_W  registered current PC to ALU
- fetch_valid  out  1  registered, ROM output this cycle is a real instruction
- ras_depth  out  clog2(RAS_DEPTH)+1  registered stack occupancy
- ras_err  out  1  registered stack fault flag (present only with macro, see Configuration)

## Operation
- States: BOOT, RUN, HOLD, plus ERR with the macro.
- BOOT: entered on reset. rom_addr=0. pc stays 0. fetch_valid=0. Always goes to RUN on the next edge.
- RUN/HOLD: the next address is chosen by priority, highest first:
  - hold: rom_addr=pc[ROM_AW-1:0]. pc is unchanged, the stack is unchanged, and the state goes to HOLD.
  - ret: pop. rom_addr=top of stack. depth decrements.
  - call: push (pc+1) truncated to ROM_AW. rom_addr=call_target[ROM_AW-1:0]. depth increments.
  - br_taken: rom_addr=br_target[ROM_AW-1:0].
  - otherwise: rom_addr=pc[ROM_AW-1:0]+1. This wraps to 0 at 2^ROM_AW-1.
- Any non-hold cycle returns the state to RUN.
- Simultaneous events:
  - call together with ret: ret wins and call is ignored.
  - br_taken together with call or ret: br_taken is ignored.
  - Any of these together with hold: all are ignored. The requester must hold its request until hold drops.
- pc update: pc <= zero-extended rom_addr on every non-hold edge. The upper PC_W-ROM_AW bits are always 0. br_target/call_target upper bits are discarded.
- Stack full (depth==RAS_DEPTH) with call, no macro: the push overwrites the oldest entry (circular) and depth saturates at RAS_DEPTH.
- Stack empty with ret, no macro: rom_addr=0 and depth stays 0.
- fetch_valid: 0 in BOOT, in reset, and on the first cycle after any redirect (ret/call/br_taken); 1 otherwise. During HOLD it keeps its previous value.

## Timing
- rom_addr is combinational from registered state plus the current inputs. There is no latency from a request to the ROM address.
- pc reflects rom_addr one edge later.
- The ROM is synchronous, so the instruction at pc is presented in the cycle after pc updates.
- Redirects cost exactly one bubble (fetch_valid=0 for one cycle).
- Reset asserted mid-operation, including mid-HOLD or in ERR, takes effect on the next edge. Reset values:
  - pc=0, depth=0, stack contents=0
  - fetch_valid=0, ras_err=0
  - state=BOOT
  - rom_addr=0 while rst_s=1

## Configuration
- Macro FETCH_SEQ_RAS_CHECK_EN.
- When defined:
  - A call with a full stack, or a ret with an empty stack, sets ras_err=1 and enters ERR. The faulting push/pop is not performed.
  - ERR freezes pc, rom_addr=pc, fetch_valid=0, and ignores all requests until reset. ras_err is sticky until reset.
- When undefined: the ras_err port and the ERR state do not exist, and the wrap/zero behaviour above applies.

## Structure
- Shared package fetch_pkg:
  - state enum (BOOT/RUN/HOLD/ERR)
  - next-address select enum (SEL_HOLD/SEL_RET/SEL_CALL/SEL_BR/SEL_SEQ)
  - default width constants
- One sub-module: fetch_ras, the return-address stack.
  - Inputs: push, pop, push data.
  - Outputs: top, depth, full, empty.
  - Circular pointer.
- The priority select and FSM stay in fetch_seq.

## Test plan
- Reset then free run: rst_s=1 for 2 cycles, then release. pc sequence 0,0,1,2,3; fetch_valid goes 0 until the second fetch.
- Branch: at pc=5 assert br_taken with br_target=0x0123. Next pc=0x0123, fetch_valid=0 for one cycle, then pc=0x0124.
- Call/return:
  - At pc=0x10, call to 0x200: pc=0x200, ras_depth=1.
  - At pc=0x203, ret: pc=0x11, ras_depth=0.
- Hold priority: at pc=7 assert hold, br_taken and call together for 3 cycles. pc stays 7 and depth is unchanged. Drop hold with br_taken still high: pc=br_target.
- Wrap: ROM_AW=10 at pc=0x3FF with no request gives pc=0.
- Overflow, RAS_DEPTH=8, 9 nested calls:
  - Without macro: depth=8, and the 8 rets return the 8 most recent return addresses.
  - With FETCH_SEQ_RAS_CHECK_EN: ras_err=1 on the 9th call, pc frozen, cleared only by rst_s.
